aes_tx_sched: RTL and testbench

//  Scheduler in front of the byte serializer aes_tx. Buffers 128-bit result blocks from two

---
 rtl/aes_tx_pkg.sv | 34 +++
 rtl/aes_tx_rate_gen.sv | 40 ++++
 rtl/aes_tx_sched.sv | 147 ++++++++++++++
 tb/tb_aes_tx_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_tx_pkg.sv
// Shared types and widths for the aes_tx scheduler.
//   BLK_W  : block width (AES state)
//   DIV_W  : width of the tx_en pacing divider
//   CNT_W  : width of the optional per-source grant counters
//   src_e  : producer id (SRC0 = encrypt core, SRC1 = decrypt core)
//   out_state_e : output slot state
package aes_tx_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Round-robin pick: a lone requester wins; on a tie the source not granted last wins.
  function automatic src_e rr_pick(input logic v0, input logic v1, input src_e last);
    if (v0 && v1) begin
      return (last == SRC0) ? SRC1 : SRC0;
    end else if (v0) begin
      return SRC0;
    end else begin
      return SRC1;
    end
  endfunction

endpackage

// File: rtl/aes_tx_rate_gen.sv
// Pacing strobe for the byte serializer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   div        : strobe period minus one (0 = strobe every cycle)
//   tx_en      : one-cycle strobe, registered
module aes_tx_rate_gen
  import aes_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  output logic             tx_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tx_en_q, tx_en_d;

  // ">=" rather than "==" so a div lowered below the running count still fires and reloads.
  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    tx_en_d = 1'b0;
    if (cnt_q >= div) begin
      cnt_d   = '0;
      tx_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tx_en_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tx_en_q <= tx_en_d;
    end
  end

  assign tx_en = tx_en_q;

endmodule

// File: rtl/aes_tx_sched.sv
// Round-robin scheduler feeding 128-bit blocks from two producers into the aes_tx
// serializer's single data slot, plus the serializer's en pacing strobe.
// Ports:
//   s0_*/s1_*  : valid/ready block inputs from the encrypt (src0) and decrypt (src1) cores
//   tx_data    : block presented to the serializer
//   tx_empty   : no block presented
//   tx_require : serializer pulse, presented block consumed
//   tx_en      : serializer enable strobe, period div+1
//   busy       : any block buffered anywhere
//   err        : sticky, tx_require seen while nothing was presented
//   cnt0/cnt1  : per-source grant counters, only when AES_TX_SCHED_CNT_EN is defined
module aes_tx_sched
  import aes_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [BLK_W-1:0] s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [BLK_W-1:0] s1_data,
  output logic             s1_ready,
  output logic [BLK_W-1:0] tx_data,
  output logic             tx_empty,
  input  logic             tx_require,
  output logic             tx_en,
  input  logic [DIV_W-1:0] div,
  output logic             busy,
`ifdef AES_TX_SCHED_CNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  output logic             err
);

  out_state_e                  state_q, state_d;
  logic [1:0]                  hold_valid_q, hold_valid_d;
  logic [1:0][BLK_W-1:0]       hold_data_q, hold_data_d;
  logic [1:0]                  ready_q, ready_d;
  logic [BLK_W-1:0]            tx_data_q, tx_data_d;
  logic                        tx_empty_q, tx_empty_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  src_e                        last_grant_q, last_grant_d;
  src_e                        gsrc;
  logic                        slot_free;
  logic                        grant;
`ifdef AES_TX_SCHED_CNT_EN
  logic [1:0][CNT_W-1:0]       gcnt_q, gcnt_d;
`endif

  // Slot/hold bookkeeping: accept into free holds, grant one hold into a free slot.
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    tx_data_d    = tx_data_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    grant        = 1'b0;
`ifdef AES_TX_SCHED_CNT_EN
    gcnt_d       = gcnt_q;
`endif
    gsrc      = rr_pick(hold_valid_q[0], hold_valid_q[1], last_grant_q);
    slot_free = (state_q == ST_EMPTY) || tx_require;

    if (tx_require && (state_q == ST_EMPTY)) begin
      err_d = 1'b1;
    end

    if (slot_free && (|hold_valid_q)) begin
      grant              = 1'b1;
      tx_data_d          = hold_data_q[gsrc];
      hold_valid_d[gsrc] = 1'b0;
      last_grant_d       = gsrc;
      state_d            = ST_FULL;
`ifdef AES_TX_SCHED_CNT_EN
      gcnt_d[gsrc]       = gcnt_q[gsrc] + CNT_W'(1);
`endif
    end else if (slot_free) begin
      state_d = ST_EMPTY;
    end

    // A hold being granted has ready=0, so accept and grant never hit the same entry.
    if (s0_valid && ready_q[0]) begin
      hold_valid_d[0] = 1'b1;
      hold_data_d[0]  = s0_data;
    end
    if (s1_valid && ready_q[1]) begin
      hold_valid_d[1] = 1'b1;
      hold_data_d[1]  = s1_data;
    end

    ready_d    = ~hold_valid_d;
    tx_empty_d = (state_d == ST_EMPTY);
    busy_d     = (|hold_valid_d) || (state_d == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      ready_q      <= 2'b11;
      tx_data_q    <= '0;
      tx_empty_q   <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= SRC1;
`ifdef AES_TX_SCHED_CNT_EN
      gcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      ready_q      <= ready_d;
      tx_data_q    <= tx_data_d;
      tx_empty_q   <= tx_empty_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
`ifdef AES_TX_SCHED_CNT_EN
      gcnt_q       <= gcnt_d;
`endif
    end
  end

  aes_tx_rate_gen u_rate_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div),
    .tx_en (tx_en)
  );

  assign s0_ready = ready_q[0];
  assign s1_ready = ready_q[1];
  assign tx_data  = tx_data_q;
  assign tx_empty = tx_empty_q;
  assign busy     = busy_q;
  assign err      = err_q;
`ifdef AES_TX_SCHED_CNT_EN
  assign cnt0     = gcnt_q[0];
  assign cnt1     = gcnt_q[1];
`endif

endmodule

// File: tb/tb_aes_tx_sched.sv
// Randomized scoreboard bench for aes_tx_sched: a reference model queues the expected
// presentation order, a negedge monitor pops it whenever a new block is presented.
module tb_aes_tx_sched;
  import aes_tx_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s0_valid, s1_valid;
  logic [BLK_W-1:0] s0_data, s1_data;
  logic             s0_ready, s1_ready;
  logic [BLK_W-1:0] tx_data;
  logic             tx_empty, tx_require, tx_en, busy, err;
  logic [DIV_W-1:0] div;
`ifdef AES_TX_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  aes_tx_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_valid   (s0_valid),
    .s0_data    (s0_data),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_data    (s1_data),
    .s1_ready   (s1_ready),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .tx_require (tx_require),
    .tx_en      (tx_en),
    .div        (div),
    .busy       (busy),
`ifdef AES_TX_SCHED_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two one-deep producer buffers, one presentation slot, round-robin on ties,
  // and a "cycles since last strobe" counter for the pacing strobe.
  bit               m_hv [2];
  logic [BLK_W-1:0] m_hd [2];
  bit               m_out_v;
  int               m_last;        // source granted most recently
  bit               m_err;
  bit               m_en;
  int               m_since;       // cycles elapsed since last strobe
  logic [15:0]      m_gcnt [2];
  logic [BLK_W-1:0] expq [$];
  bit               m_a0, m_a1, m_free;
  int               m_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hv[0] = 0; m_hv[1] = 0;
      m_out_v = 0; m_last = 1; m_err = 0; m_en = 0; m_since = 0;
      m_gcnt[0] = '0; m_gcnt[1] = '0;
      expq.delete();
    end else begin
      m_a0   = s0_valid && !m_hv[0];
      m_a1   = s1_valid && !m_hv[1];
      m_free = !m_out_v || tx_require;
      if (tx_require && !m_out_v) m_err = 1;
      if (m_free && (m_hv[0] || m_hv[1])) begin
        if (m_hv[0] && m_hv[1]) m_g = 1 - m_last;
        else                    m_g = m_hv[0] ? 0 : 1;
        expq.push_back(m_hd[m_g]);
        m_hv[m_g]   = 0;
        m_last      = m_g;
        m_out_v     = 1;
        m_gcnt[m_g] = m_gcnt[m_g] + 16'd1;
      end else if (m_free) begin
        m_out_v = 0;
      end
      if (m_a0) begin m_hv[0] = 1; m_hd[0] = s0_data; end
      if (m_a1) begin m_hv[1] = 1; m_hd[1] = s1_data; end
      if (m_since >= int'(div)) begin
        m_en = 1; m_since = 0;
      end else begin
        m_en = 0; m_since++;
      end
    end
  end

  // ---------------- monitor ----------------
  bit               last_empty = 1;
  bit               last_req = 0;
  logic [BLK_W-1:0] exp_blk;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_empty = 1;
      last_req   = 0;
    end else begin
      chk("tx_en", tx_en, m_en);
      chk("tx_empty", tx_empty, !m_out_v);
      chk("s0_ready", s0_ready, !m_hv[0]);
      chk("s1_ready", s1_ready, !m_hv[1]);
      chk("busy", busy, m_hv[0] || m_hv[1] || m_out_v);
      chk("err", err, m_err);
`ifdef AES_TX_SCHED_CNT_EN
      chk("cnt0", cnt0, m_gcnt[0]);
      chk("cnt1", cnt1, m_gcnt[1]);
`endif
      // A new block is presented after the slot was empty or was just consumed.
      if (!tx_empty && (last_empty || last_req)) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_data: got %h expected no new block at %0t", tx_data, $time);
        end else begin
          exp_blk = expq.pop_front();
          chk("tx_data", tx_data, exp_blk);
        end
      end
      last_empty = tx_empty;
      last_req   = tx_require;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BLK_W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    int budget;
    budget = 40;
    s0_valid = 0; s1_valid = 0;
    while ((busy || !tx_empty) && budget > 0) begin
      tx_require = 1; step();
      tx_require = 0; step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got busy=%0b expected idle within budget", busy);
    end
  endtask

  logic [BLK_W-1:0] vec;

  initial begin
    rst_n = 0; s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
    tx_require = 0; div = '0;
    repeat (3) step();
    chk("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_s0_ready", s0_ready, 1'b1);
    chk("rst_s1_ready", s1_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_data", tx_data, '0);
    rst_n = 1;
    repeat (5) step();

    // Single block from src0: visible two edges after being offered.
    vec = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    s0_valid = 1; s0_data = vec;
    step();
    s0_valid = 0; s0_data = rnd_blk();
    step();
    chk("lat_tx_data", tx_data, vec);
    chk("lat_tx_empty", tx_empty, 1'b0);
    repeat (3) step();
    chk("hold_tx_data", tx_data, vec);
    tx_require = 1; step();
    tx_require = 0;
    chk("req_tx_empty", tx_empty, 1'b1);
    repeat (2) step();

    // Both sources saturated, serializer pulls every 16 cycles.
    for (int c = 0; c < 128; c++) begin
      s0_valid = 1; s1_valid = 1;
      s0_data = rnd_blk(); s1_data = rnd_blk();
      tx_require = (c % 16 == 15);
      step();
    end
    tx_require = 0;
    drain();

    // Pacing: period 4, then lower div while the count sits at 2.
    div = 8'd3;
    repeat (12) step();
    begin
      int budget;
      budget = 10;
      while (m_since != 2 && budget > 0) begin step(); budget--; end
      if (budget == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL div_wait: got count %0d expected 2 within budget", m_since);
      end
    end
    div = 8'd1;
    step();
    chk("div_lower_tx_en", tx_en, 1'b1);
    repeat (8) step();

    // Require with nothing presented: sticky error, no datapath effect.
    drain();
    tx_require = 1; step();
    tx_require = 0;
    chk("err_set", err, 1'b1);
    chk("err_no_grant", tx_empty, 1'b1);
    repeat (4) step();
    chk("err_sticky", err, 1'b1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) div = DIV_W'($urandom_range(0, 4));
      s0_valid   = ($urandom % 2) == 1;
      s1_valid   = ($urandom % 2) == 1;
      s0_data    = rnd_blk();
      s1_data    = rnd_blk();
      tx_require = ($urandom % 4) == 0;
      step();
    end

    // Reset with both holds and the slot occupied.
    tx_require = 0; s0_valid = 1; s1_valid = 1; div = 8'd2;
    s0_data = rnd_blk(); s1_data = rnd_blk();
    repeat (4) step();
    chk("full_busy", busy, 1'b1);
    chk("full_s0_ready", s0_ready, 1'b0);
    chk("full_s1_ready", s1_ready, 1'b0);
    chk("full_tx_empty", tx_empty, 1'b0);
    rst_n = 0; s0_valid = 0; s1_valid = 0;
    @(negedge clk);
    chk("rst2_tx_empty", tx_empty, 1'b1);
    chk("rst2_s0_ready", s0_ready, 1'b1);
    chk("rst2_s1_ready", s1_ready, 1'b1);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_err", err, 1'b0);
    step();
    rst_n = 1;
    repeat (6) step();
    chk("post_rst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
